uart_rx_gen: RTL and testbench
==============================

UART_RX_GEN -- requirements
Module: uart_rx_gen

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 435, meaning clock cycles per bit (main clock / 115200); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-004 SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity, 0 = even; used only with UART_RX_PARITY_EN.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-007 SHALL have port rx, input, 1, meaning the asynchronous serial line; it idles high.
REQ-008 SHALL have port data, output, DATA_BITS, meaning the last good received word, LSB first on the line.
REQ-009 SHALL have port valid, output, 1, meaning a one-cycle pulse when data is updated.
REQ-010 SHALL have port frame_err, output, 1, meaning a one-cycle pulse when a stop bit is sampled low.
REQ-011 SHALL have port parity_err, output, 1, meaning a one-cycle pulse on a parity mismatch; tied 0 without the macro.
REQ-012 SHALL have port busy, output, 1, meaning high in every state except IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE, DONE.
REQ-015 IDLE SHALL go to START on rx_s == 0 and clear the bit counter and cycle counter.
REQ-016 START SHALL count (CLK_PER_BIT-1)/2 cycles, then sample rx_s: 0 -> DATA; 1 -> IDLE (false start, no pulse on any output).
REQ-017 DATA SHALL sample rx_s every CLK_PER_BIT cycles into bit index 0..DATA_BITS-1, LSB first.
REQ-018 After the last data bit, DATA SHALL go to PARITY when the macro is defined, else to STOP.
REQ-019 PARITY SHALL sample one bit after CLK_PER_BIT cycles and compare it with the XOR of the data bits (inverted when PARITY_ODD = 1).
REQ-020 STOP SHALL sample STOP_BITS bits at CLK_PER_BIT spacing; any zero sample sets a frame error.
REQ-021 When all stop bits are 1, STOP SHALL go to DONE.
REQ-022 On a frame error, STOP SHALL go to WAIT_IDLE; WAIT_IDLE SHALL hold until rx_s == 1 (break condition) and then go to IDLE.
REQ-023 DONE SHALL last exactly one cycle and then go to IDLE.
REQ-024 With no error, DONE SHALL load data and pulse valid.
REQ-025 With a parity error, DONE SHALL pulse parity_err, leave data unchanged and not pulse valid.
REQ-026 frame_err SHALL pulse for one cycle on entry to WAIT_IDLE; data and valid SHALL be unchanged.
REQ-027 valid, frame_err and parity_err SHALL be mutually exclusive and each high for at most one cycle per frame.
REQ-028 Latency SHALL be: valid rises exactly 1 cycle after the mid-bit sample of the final stop bit.
REQ-029 The cycle counter SHALL be $clog2(CLK_PER_BIT) bits wide and reset to 0 at every sample point (no wrap-around).
REQ-030 A new start bit SHALL be accepted on the cycle after DONE, so back-to-back frames are received without loss.

Reset
REQ-031 rst asserted SHALL immediately force state IDLE, all counters 0, data 0, and valid, frame_err, parity_err and busy 0.
REQ-032 Both synchroniser flops SHALL reset to 1.
REQ-033 Reset mid-frame SHALL discard the partial frame with no output pulse; after reset releases, reception restarts on the next falling edge.

Configuration
REQ-034 Macro UART_RX_PARITY_EN, when defined, SHALL include the PARITY state and parity check; each frame is then 1 + DATA_BITS + 1 + STOP_BITS bits.
REQ-035 Without UART_RX_PARITY_EN, the PARITY state and logic SHALL be absent and parity_err SHALL be constant 0.

Structure
REQ-036 Package uart_pkg SHALL hold the state enum typedef and the state encodings shared with the future uart_tx_gen.
REQ-037 Sub-module uart_sync SHALL implement the 2-flop synchroniser with a reset value parameter.

Verification (CLK_PER_BIT=16)
REQ-038 DATA_BITS=8, STOP_BITS=1, frame 0xA5 -> one valid pulse, data=0xA5, 1 cycle after the stop mid-sample.
REQ-039 Macro on, PARITY_ODD=0, 0x03 sent with parity bit 1 -> parity_err pulse, no valid, data holds its previous value.
REQ-040 STOP_BITS=2, second stop bit driven 0, rx then held low for 40 cycles -> one frame_err pulse, busy high until rx returns to 1.
REQ-041 rx glitched low for 5 cycles -> no output pulses, busy returns to 0.
REQ-042 DATA_BITS=9, frames 0x1FF and 0x000 back-to-back -> two valid pulses with the correct data.
REQ-043 rst asserted during data bit 4 -> all outputs 0 at once; the following frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings common to the receiver and the future transmitter.
// StParity exists only when UART_RX_PARITY_EN is defined; the other encodings stay fixed.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
`ifdef UART_RX_PARITY_EN
    StParity   = 3'd3,
`endif
    StStop     = 3'd4,
    StWaitIdle = 3'd5,
    StDone     = 3'd6
  } uart_state_e;

  // Wide enough to index up to 9 data bits or 2 stop bits.
  localparam int unsigned BitCntW = 4;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to ResetVal so an idle-high line never looks like an edge out of reset.
module uart_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= ResetVal;
      q      <= ResetVal;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_gen.sv
// UART receiver: mid-bit sampling of an idle-high line, LSB first, 1 or 2 stop bits.
// Optional parity check is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = 435,
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter bit          PARITY_ODD  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(CLK_PER_BIT);
  localparam logic [CntW-1:0] FullCnt = CntW'(CLK_PER_BIT - 1);
  // Start bit is re-checked near its centre, then every full bit period after that.
  localparam logic [CntW-1:0] HalfCnt = CntW'((CLK_PER_BIT - 1) / 2 - 1);
  localparam logic [BitCntW-1:0] LastData = BitCntW'(DATA_BITS - 1);
  localparam logic [BitCntW-1:0] LastStop = BitCntW'(STOP_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitCntW-1:0]   bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
  logic                 par_bad_q, par_bad_d;
`endif

  uart_sync #(
    .ResetVal (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullCnt) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LastData) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == FullCnt) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shreg_q) ^ PARITY_ODD;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == FullCnt) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = StWaitIdle;
            ferr_d  = 1'b1;
          end else if (bit_q == LastStop) begin
            // Outputs are registered so they are valid during the single DONE cycle.
            state_d = StDone;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shreg_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shreg_q;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StWaitIdle: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_gen.sv
// Scoreboard bench for uart_rx_gen: three receivers (8N1, 8N2, 9N1) at 16 clocks per bit.
// Frames push their expected pulse (kind, cycle, data) into a queue; a monitor pops on each pulse.
module tb_uart_rx_gen;

  localparam int Cpb = 16;
  localparam bit POdd = 1'b0;
  // Edge at which the start bit is judged, counted from the edge after which rx fell:
  // 2 synchroniser flops + 1 IDLE cycle + (Cpb-1)/2 START cycles.
  localparam int StartDec = 3 + (Cpb - 1) / 2;

  localparam int KValid = 0;
  localparam int KFrame = 1;
  localparam int KParity = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic [7:0] data_a, data_b;
  logic [8:0] data_c;
  logic valid_a, frame_err_a, parity_err_a, busy_a;
  logic valid_b, frame_err_b, parity_err_b, busy_b;
  logic valid_c, frame_err_c, parity_err_c, busy_c;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         kind;
    int         cyc;
    logic [8:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  logic [8:0] last_good [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_gen #(.CLK_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(POdd)) dut_a (
    .clk (clk), .rst (rst), .rx (rx_a), .data (data_a), .valid (valid_a),
    .frame_err (frame_err_a), .parity_err (parity_err_a), .busy (busy_a)
  );

  uart_rx_gen #(.CLK_PER_BIT(Cpb), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(POdd)) dut_b (
    .clk (clk), .rst (rst), .rx (rx_b), .data (data_b), .valid (valid_b),
    .frame_err (frame_err_b), .parity_err (parity_err_b), .busy (busy_b)
  );

  uart_rx_gen #(.CLK_PER_BIT(Cpb), .DATA_BITS(9), .STOP_BITS(1), .PARITY_ODD(POdd)) dut_c (
    .clk (clk), .rst (rst), .rx (rx_c), .data (data_c), .valid (valid_c),
    .frame_err (frame_err_c), .parity_err (parity_err_c), .busy (busy_c)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic set_rx(input int d, input logic v);
    case (d)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic push(input int d, input exp_t e);
    case (d)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic mon(input int d, input logic v, input logic fe, input logic pe,
                     input logic [8:0] dat);
    exp_t e;
    bit   ok;
    int   kind;
    ok = 1'b0;
    if (v || fe || pe) begin
      kind = v ? KValid : (fe ? KFrame : KParity);
      check($sformatf("dut%0d one pulse at a time", d), $countones({v, fe, pe}), 1);
      case (d)
        0:       if (q_a.size() > 0) begin e = q_a.pop_front(); ok = 1'b1; end
        1:       if (q_b.size() > 0) begin e = q_b.pop_front(); ok = 1'b1; end
        default: if (q_c.size() > 0) begin e = q_c.pop_front(); ok = 1'b1; end
      endcase
      if (!ok) begin
        tests++;
        fails++;
        $display("FAIL dut%0d unexpected pulse: got kind %0d, required none", d, kind);
      end else begin
        check($sformatf("dut%0d pulse kind", d), kind, e.kind);
        check($sformatf("dut%0d pulse cycle", d), cyc, e.cyc);
        check($sformatf("dut%0d data", d), dat, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, valid_a, frame_err_a, parity_err_a, {1'b0, data_a});
    mon(1, valid_b, frame_err_b, parity_err_b, {1'b0, data_b});
    mon(2, valid_c, frame_err_c, parity_err_c, data_c);
  end

  // Called #1 after a rising edge; returns #1 after the edge that ends the last bit.
  task automatic frame(input int d, input logic [8:0] w, input bit flip_par, input bit bad_stop);
    logic [15:0] b;
    int   n;
    int   dbits;
    int   nstop;
    exp_t e;
    dbits = (d == 2) ? 9 : 8;
    nstop = (d == 1) ? 2 : 1;
    b = '1;
    n = 0;
    b[n] = 1'b0;
    n++;
    for (int i = 0; i < dbits; i++) begin
      b[n] = w[i];
      n++;
    end
`ifdef UART_RX_PARITY_EN
    b[n] = (^w) ^ POdd ^ flip_par;
    n++;
`endif
    for (int s = 0; s < nstop; s++) begin
      b[n] = !(bad_stop && (s == nstop - 1));
      n++;
    end
    e.cyc = cyc + StartDec + Cpb * (n - 1);
    if (bad_stop) begin
      e.kind = KFrame;
      e.data = last_good[d];
    end else if (flip_par) begin
      e.kind = KParity;
      e.data = last_good[d];
    end else begin
      e.kind = KValid;
      e.data = w;
      last_good[d] = w;
    end
    push(d, e);
    for (int i = 0; i < n; i++) begin
      set_rx(d, b[i]);
      repeat (Cpb) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] w;
    for (int i = 0; i < 3; i++) last_good[i] = '0;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset valid", valid_a, 0);
    check("reset frame_err", frame_err_a, 0);
    check("reset parity_err", parity_err_a, 0);
    check("reset busy a", busy_a, 0);
    check("reset data a", data_a, 0);
    check("reset busy b", busy_b, 0);
    check("reset busy c", busy_c, 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    frame(0, 9'h0A5, 1'b0, 1'b0);
    frame(0, 9'h05A, 1'b0, 1'b0);
    frame(0, 9'h0FF, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    // Short low glitch: START must reject it without any pulse.
    set_rx(0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("glitch busy during", busy_a, 1);
    set_rx(0, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    check("glitch busy after", busy_a, 0);

`ifdef UART_RX_PARITY_EN
    frame(0, 9'h003, 1'b1, 1'b0);
    frame(0, 9'h0C3, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
`endif

    frame(1, 9'h03C, 1'b0, 1'b0);
    frame(1, 9'h081, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    check("break busy held", busy_b, 1);
    set_rx(1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("break busy released", busy_b, 0);

    frame(2, 9'h1FF, 1'b0, 1'b0);
    frame(2, 9'h000, 1'b0, 1'b0);
    frame(2, 9'h155, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;

    // Abort a frame during data bit 4 with an asynchronous reset.
    w = 8'h3C;
    set_rx(0, 1'b0);
    repeat (Cpb) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      set_rx(0, w[i]);
      repeat (Cpb) @(posedge clk);
      #1;
    end
    set_rx(0, w[4]);
    repeat (8) @(posedge clk);
    #2;
    check("mid-frame busy", busy_a, 1);
    rst = 1'b1;
    #1;
    check("async reset busy", busy_a, 0);
    check("async reset valid", valid_a, 0);
    check("async reset frame_err", frame_err_a, 0);
    check("async reset parity_err", parity_err_a, 0);
    check("async reset data a", data_a, 0);
    check("async reset data b", data_b, 0);
    check("async reset data c", data_c, 0);
    for (int i = 0; i < 3; i++) last_good[i] = '0;
    set_rx(0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    frame(0, 9'h03C, 1'b0, 1'b0);

    repeat (30) @(posedge clk);
    #1;
    check("dut0 all expected pulses seen", q_a.size(), 0);
    check("dut1 all expected pulses seen", q_b.size(), 0);
    check("dut2 all expected pulses seen", q_c.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
